// File: rtl/walk_phase_timer_if.sv
// Controller-side handshake bundle for the walk-phase timer.
// master drives the button and strobes; slave returns the phase status.
interface walk_phase_timer_if;
  logic       walk_btn;
  logic       start;
  logic       abort;
  logic [6:0] ten_sec;
  logic       walk_req;
  logic       walk_active;
  logic       walk_done;

  modport master (
    output walk_btn, start, abort,
    input  ten_sec, walk_req, walk_active, walk_done
  );

  modport slave (
    input  walk_btn, start, abort,
    output ten_sec, walk_req, walk_active, walk_done
  );
endinterface

// File: rtl/walk_phase_timer.sv
// Pedestrian walk-phase time base: latches a request, counts 0.1 s ticks once granted, pulses walk_done at the end.
// Outputs decode registered state, so they follow the causing input by one cycle; start/abort are strobes with no backpressure.
module walk_phase_timer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int PHASE_TICKS = 100
) (
  input logic               clk,
  input logic               rst_n,
  walk_phase_timer_if.slave bus
);
  localparam int              DIV      = CLK_HZ / TICK_HZ;
  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   DIV_LAST = PW'(DIV - 1);
  localparam logic [6:0]      TEN_LAST = 7'(PHASE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WALK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic [PW-1:0] presc_q;
  logic [6:0]    ten_q;
  logic          pending_q;
  logic          tick;
  logic          last_tick;

  assign tick      = (state_q == WALK) && (presc_q == DIV_LAST);
  assign last_tick = tick && (ten_q == TEN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A request left over from an aborted phase is replayed straight out of IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (bus.walk_btn || pending_q) state_nxt = REQ;
      REQ:  if (bus.start) state_nxt = WALK;
      WALK: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (last_tick) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = (pending_q || bus.walk_btn) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.walk_req    = 1'b0;
    bus.walk_active = 1'b0;
    bus.walk_done   = 1'b0;
    case (state_q)
      REQ:     bus.walk_req    = 1'b1;
      WALK:    bus.walk_active = 1'b1;
      DONE:    bus.walk_done   = 1'b1;
      default: ;
    endcase
  end

  assign bus.ten_sec = ten_q;

  // Prescaler is held at zero outside WALK so the first tick lands DIV cycles after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if ((state_q == WALK) && !tick) begin
      presc_q <= presc_q + PW'(1);
    end else begin
      presc_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_q <= '0;
    end else if (state_q != WALK || bus.abort || last_tick) begin
      ten_q <= '0;
    end else if (tick) begin
      ten_q <= ten_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (state_q == WALK) begin
      if (bus.walk_btn) pending_q <= 1'b1;
    end else if (state_q == IDLE || state_q == DONE) begin
      pending_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_walk_phase_timer.sv
// Directed walk-phase scenarios followed by random button/start/abort traffic,
// every cycle compared against an elapsed-cycle reference model.
module tb_walk_phase_timer;
  localparam int CLK_HZ      = 100;
  localparam int TICK_HZ     = 10;
  localparam int PHASE_TICKS = 100;
  localparam int DIV         = CLK_HZ / TICK_HZ;
  localparam int PHASE_CYC   = DIV * PHASE_TICKS;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  walk_phase_timer_if wif ();

  walk_phase_timer #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .PHASE_TICKS(PHASE_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: whether a request is posted, whether a phase runs and for how many
  // cycles, a done pulse flag and a remembered mid-phase press.
  bit m_req;
  bit m_walk;
  bit m_done;
  bit m_pend;
  int m_cyc;

  task automatic model_reset();
    m_req  = 1'b0;
    m_walk = 1'b0;
    m_done = 1'b0;
    m_pend = 1'b0;
    m_cyc  = 0;
  endtask

  task automatic model_step(input bit btn, input bit st, input bit ab);
    if (m_done) begin
      m_done = 1'b0;
      m_req  = m_pend || btn;
      m_pend = 1'b0;
    end else if (m_walk) begin
      if (btn) m_pend = 1'b1;
      if (ab) begin
        m_walk = 1'b0;
        m_cyc  = 0;
      end else begin
        m_cyc = m_cyc + 1;
        if (m_cyc == PHASE_CYC) begin
          m_walk = 1'b0;
          m_done = 1'b1;
          m_cyc  = 0;
        end
      end
    end else if (m_req) begin
      if (st) begin
        m_req  = 1'b0;
        m_walk = 1'b1;
        m_cyc  = 0;
      end
    end else if (btn || m_pend) begin
      m_req  = 1'b1;
      m_pend = 1'b0;
    end
  endtask

  function automatic logic [9:0] exp_outs();
    logic [6:0] ten;
    ten = m_walk ? 7'(m_cyc / DIV) : 7'd0;
    return {ten, m_req, m_walk, m_done};
  endfunction

  function automatic logic [9:0] outs();
    return {wif.ten_sec, wif.walk_req, wif.walk_active, wif.walk_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(wif.walk_btn, wif.start, wif.abort);
    #1;
    chk("model", 32'(outs()), 32'(exp_outs()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b1;
    wif.walk_btn = 1'b0;
    wif.start    = 1'b0;
    wif.abort    = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(outs()), 0);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", 32'(outs()), 0);
    rst_n = 1'b1;
    run(50);
    chk("idle50", 32'(outs()), 0);

    // Full phase with the request five cycles ahead of the grant.
    wif.walk_btn = 1'b1; cycle(); wif.walk_btn = 1'b0;
    chk("req_after_press", 32'(wif.walk_req), 1);
    run(4);
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    chk("active_after_start", 32'(wif.walk_active), 1);
    chk("ten_at_entry", 32'(wif.ten_sec), 0);
    run(9);
    chk("ten_at_9", 32'(wif.ten_sec), 0);
    run(1);
    chk("ten_at_10", 32'(wif.ten_sec), 1);
    run(490);
    chk("ten_at_500", 32'(wif.ten_sec), 50);
    run(490);
    chk("ten_at_990", 32'(wif.ten_sec), 99);
    run(9);
    chk("active_at_999", 32'({wif.walk_active, wif.walk_done}), 2);
    run(1);
    chk("done_at_1000", 32'({wif.walk_req, wif.walk_active, wif.walk_done}), 1);
    chk("ten_in_done", 32'(wif.ten_sec), 0);
    run(1);
    chk("idle_after_done", 32'(outs()), 0);

    // Grants that must not open a phase.
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    chk("start_no_req", 32'({wif.walk_req, wif.walk_active}), 0);
    wif.walk_btn = 1'b1; wif.start = 1'b1; cycle();
    wif.walk_btn = 1'b0; wif.start = 1'b0;
    chk("coincident_no_walk", 32'(wif.walk_active), 0);
    chk("coincident_req", 32'(wif.walk_req), 1);
    run(2);
    chk("req_holds", 32'(wif.walk_req), 1);

    // Press during the phase queues the next request after completion.
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    run(300);
    chk("ten_at_30", 32'(wif.ten_sec), 30);
    wif.walk_btn = 1'b1; cycle(); wif.walk_btn = 1'b0;
    chk("press_in_walk_no_effect", 32'({wif.walk_req, wif.walk_active}), 1);
    run(699);
    chk("done_with_pending", 32'(wif.walk_done), 1);
    run(1);
    chk("req_after_done", 32'({wif.walk_req, wif.walk_active, wif.walk_done}), 4);

    // Abort keeps the earlier press, which re-raises the request a cycle later.
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    run(50);
    wif.walk_btn = 1'b1; cycle(); wif.walk_btn = 1'b0;
    run(369);
    chk("ten_at_42", 32'(wif.ten_sec), 42);
    wif.abort = 1'b1; cycle(); wif.abort = 1'b0;
    chk("abort_idle", 32'(outs()), 0);
    run(1);
    chk("req_after_abort", 32'(wif.walk_req), 1);

    // Asynchronous reset mid-phase, mid-prescale.
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    run(775);
    chk("ten_at_77", 32'(wif.ten_sec), 77);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_mid_phase", 32'(outs()), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wif.start = 1'b1; cycle(); wif.start = 1'b0;
    chk("start_after_rst", 32'({wif.walk_req, wif.walk_active}), 0);
    run(5);
    wif.walk_btn = 1'b1; cycle(); wif.walk_btn = 1'b0;
    chk("req_after_rst", 32'(wif.walk_req), 1);

    for (int i = 0; i < 20000; i++) begin
      wif.walk_btn = ($urandom_range(0, 99) < 3);
      wif.start    = ($urandom_range(0, 99) < 10);
      wif.abort    = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    wif.walk_btn = 1'b0;
    wif.start    = 1'b0;
    wif.abort    = 1'b0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/walk_phase_timer.md
Name: walk_phase_timer

Overview:
- Generates the pedestrian walk-phase time base for the traffic light controller.
- Latches a walk request and, once the main controller grants the walk phase, counts tenths of a second from 0 to 99 on `ten_sec`.
- `ten_sec` feeds the countdown-digit decoder downstream.
- Signals the main controller with a one-cycle `walk_done` pulse at the end of the phase.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 10, count rate of `ten_sec` in Hz (one tick = 0.1 s).
- PHASE_TICKS, 100, ticks per walk phase. Legal range 1..128.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- walk_btn  in  1  debounced, clk-synchronous pedestrian button level.
- start  in  1  one-cycle grant from the main controller: begin walk phase.
- abort  in  1  one-cycle cancel from the main controller (e.g. emergency preempt).
- ten_sec  out  7  elapsed tenths in current phase, 0..PHASE_TICKS-1.
- walk_req  out  1  pending request exists (to main controller).
- walk_active  out  1  walk phase in progress.
- walk_done  out  1  one-cycle pulse at normal phase completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; ten_sec = 0; prescaler = 0; pending = 0.
  - walk_req = 0, walk_active = 0, walk_done = 0.
- Prescaler:
  - DIV = CLK_HZ/TICK_HZ (integer). Counter runs 0..DIV-1.
  - tick asserts for one clk on the cycle the counter equals DIV-1; the counter then wraps to 0.
  - The prescaler runs only in WALK and is forced to 0 in every other state, so the first tick occurs exactly DIV cycles after WALK entry.
- State machine (registered outputs, Moore):
  - IDLE:
    - walk_btn = 1 -> REQ.
    - start is ignored in IDLE.
    - If start and walk_btn are high in the same cycle, go to REQ only; start is not honoured until a later cycle.
  - REQ:
    - walk_req = 1.
    - start = 1 -> WALK, with ten_sec = 0 and prescaler = 0.
    - Further walk_btn presses have no effect.
  - WALK:
    - walk_active = 1.
    - On tick: ten_sec += 1.
    - On tick with ten_sec == PHASE_TICKS-1: -> DONE, and ten_sec = 0 (no wrap past the terminal value).
    - walk_btn = 1 sets pending.
    - abort = 1 -> IDLE with ten_sec = 0. abort takes priority over a coincident terminal tick. No walk_done is produced and pending is retained.
    - start while in WALK is ignored.
  - DONE (exactly one cycle):
    - walk_done = 1, ten_sec = 0.
    - Next state is REQ if pending = 1 or walk_btn = 1, otherwise IDLE. pending clears.
    - abort in DONE is ignored.
  - IDLE after an abort with pending = 1 -> REQ on the next cycle, pending clears.
- Output encoding:
  - walk_req, walk_active and walk_done are mutually exclusive, and all are 0 in IDLE.
  - ten_sec changes only on tick or on a state transition; it is never above PHASE_TICKS-1.
- Reset mid-phase drops any request and any phase in progress immediately.

Test Plan (CLK_HZ=100, TICK_HZ=10, so DIV=10; PHASE_TICKS=100):
- Reset then idle 50 cycles -> all outputs 0, ten_sec = 0 throughout.
- walk_btn pulse, then start 5 cycles later:
  - walk_req goes high 1 cycle after the press.
  - walk_active goes high 1 cycle after start.
  - ten_sec = 1 at 10 cycles, 50 at 500, 99 at 990.
  - walk_done high for one cycle at 1000 cycles after WALK entry, then all outputs 0.
- start without a prior request, and start coincident with the first press:
  - No WALK entry on those cycles.
  - In the coincident case walk_req = 1 the following cycle.
- walk_btn during WALK at ten_sec = 30 -> normal walk_done, then walk_req = 1 on the next cycle.
- abort at ten_sec = 42 -> IDLE next cycle, ten_sec = 0, no walk_done.
  - With a press earlier in the phase, walk_req rises one cycle later.
- rst_n low asynchronously at ten_sec = 77, mid-prescale -> outputs 0 before the next clk edge.
  - After release, start alone has no effect until a new walk_btn press.
